// File: rtl/mealy_seq_ctrl.sv
// Drives a bit pattern into an external 1-in/3-out Mealy FSM and counts cycles whose output equals HIT_CODE.
// Optional abort input is enabled by defining MEALY_SEQ_ABORT_EN.
module mealy_seq_ctrl #(
  parameter int         PAT_W    = 16,
  parameter int         CNT_W    = 8,
  parameter logic [2:0] HIT_CODE = 3'b011,
  localparam int        LEN_W    = $clog2(PAT_W) + 1
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic [PAT_W-1:0] cmd_pattern_i,
  input  logic [LEN_W-1:0] cmd_len_i,
  output logic             fsm_rst_o,
  output logic             fsm_in_o,
  input  logic [2:0]       fsm_out_i,
  output logic             res_valid_o,
  input  logic             res_ready_i,
  output logic [CNT_W-1:0] res_hits_o,
  output logic [2:0]       res_last_o,
`ifdef MEALY_SEQ_ABORT_EN
  input  logic             abort_i,
`endif
  output logic             busy_o
);

  typedef enum logic [1:0] {IDLE, CLEAR, RUN, RESP} state_e;

  state_e           state_q, state_d;
  logic [PAT_W-1:0] pattern_q, pattern_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] hitCnt_q, hitCnt_d;
  logic [2:0]       last_q, last_d;
  logic             fsmRst_q, fsmRst_d;
  logic             fsmIn_q, fsmIn_d;
  logic             abortReq;

`ifdef MEALY_SEQ_ABORT_EN
  assign abortReq = abort_i && (state_q == CLEAR || state_q == RUN);
`else
  assign abortReq = 1'b0;
`endif

  // The pattern shifts right each RUN cycle, so bit 0 is always the next bit to drive.
  always_comb begin
    state_d   = state_q;
    pattern_d = pattern_q;
    len_d     = len_q;
    hitCnt_d  = hitCnt_q;
    last_d    = last_q;
    fsmRst_d  = 1'b0;
    fsmIn_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid_i) begin
          state_d   = CLEAR;
          pattern_d = cmd_pattern_i;
          len_d     = (cmd_len_i > LEN_W'(PAT_W)) ? LEN_W'(PAT_W) : cmd_len_i;
          hitCnt_d  = '0;
          last_d    = '0;
          fsmRst_d  = 1'b1;
        end
      end
      CLEAR: begin
        if (len_q != '0) begin
          state_d   = RUN;
          fsmIn_d   = pattern_q[0];
          pattern_d = pattern_q >> 1;
        end else begin
          state_d = RESP;
        end
      end
      RUN: begin
        if (fsm_out_i == HIT_CODE && hitCnt_q != '1) begin
          hitCnt_d = hitCnt_q + 1'b1;
        end
        if (len_q == LEN_W'(1)) begin
          state_d = RESP;
          last_d  = fsm_out_i;
        end else begin
          len_d     = len_q - 1'b1;
          fsmIn_d   = pattern_q[0];
          pattern_d = pattern_q >> 1;
        end
      end
      RESP: begin
        if (res_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (abortReq) begin
      state_d  = IDLE;
      fsmRst_d = 1'b1;
      fsmIn_d  = 1'b0;
    end
  end

  // Reset holds the driven FSM in clear until the first edge after release.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q   <= IDLE;
      pattern_q <= '0;
      len_q     <= '0;
      hitCnt_q  <= '0;
      last_q    <= '0;
      fsmRst_q  <= 1'b1;
      fsmIn_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pattern_q <= pattern_d;
      len_q     <= len_d;
      hitCnt_q  <= hitCnt_d;
      last_q    <= last_d;
      fsmRst_q  <= fsmRst_d;
      fsmIn_q   <= fsmIn_d;
    end
  end

  assign cmd_ready_o = (state_q == IDLE);
  assign res_valid_o = (state_q == RESP);
  assign busy_o      = (state_q != IDLE);
  assign fsm_rst_o   = fsmRst_q;
  assign fsm_in_o    = fsmIn_q;
  assign res_hits_o  = hitCnt_q;
  assign res_last_o  = last_q;

endmodule

// File: tb/tb_mealy_seq_ctrl.sv
// Self-checking bench: a rising-edge-detecting Mealy FSM is driven by the DUT, results checked against a pattern-level model.
module tb_mealy_seq_ctrl;

  logic        clk;
  logic        reset_ni;
  logic        cmd_valid_i;
  logic [15:0] cmd_pattern_i;
  logic [4:0]  cmd_len_i;
  logic        res_ready_i;
  logic [2:0]  fsmOut;
  logic        fsmPrev;

  logic        cmd_ready_o, fsm_rst_o, fsm_in_o, res_valid_o, busy_o;
  logic [7:0]  res_hits_o;
  logic [2:0]  res_last_o;

  logic        satCmdReady, satFsmRst, satFsmIn, satResValid, satBusy;
  logic [1:0]  satHits;
  logic [2:0]  satLast;

  int assertCount = 0;
  int failCount   = 0;

  mealy_seq_ctrl #(.PAT_W(16), .CNT_W(8), .HIT_CODE(3'b011)) dut (
    .clk_i(clk), .reset_ni(reset_ni),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_pattern_i(cmd_pattern_i), .cmd_len_i(cmd_len_i),
    .fsm_rst_o(fsm_rst_o), .fsm_in_o(fsm_in_o), .fsm_out_i(fsmOut),
    .res_valid_o(res_valid_o), .res_ready_i(res_ready_i),
    .res_hits_o(res_hits_o), .res_last_o(res_last_o), .busy_o(busy_o)
  );

  mealy_seq_ctrl #(.PAT_W(16), .CNT_W(2), .HIT_CODE(3'b011)) dutSat (
    .clk_i(clk), .reset_ni(reset_ni),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(satCmdReady),
    .cmd_pattern_i(cmd_pattern_i), .cmd_len_i(cmd_len_i),
    .fsm_rst_o(satFsmRst), .fsm_in_o(satFsmIn), .fsm_out_i(fsmOut),
    .res_valid_o(satResValid), .res_ready_i(res_ready_i),
    .res_hits_o(satHits), .res_last_o(satLast), .busy_o(satBusy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driven FSM: remembers the previous input bit; output 011 marks a 0->1 transition.
  function automatic logic [2:0] fsmCode(input logic b, input logic p);
    case ({p, b})
      2'b01:   return 3'b011;
      2'b11:   return 3'b001;
      2'b10:   return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  always @(posedge clk) fsmPrev <= fsm_rst_o ? 1'b0 : fsm_in_o;
  assign fsmOut = fsmCode(fsm_in_o, fsmPrev);

  function automatic void refModel(input logic [15:0] pat, input int len, output int eff,
                                   output int hits, output logic [2:0] last);
    logic prev;
    eff  = (len > 16) ? 16 : len;
    hits = 0;
    last = 3'b000;
    prev = 1'b0;
    for (int k = 0; k < eff; k++) begin
      if (pat[k] && !prev) hits++;
      last = fsmCode(pat[k], prev);
      prev = pat[k];
    end
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assertCount++;
    if (obs !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Runs one command from IDLE (called at a negedge) through the result handshake.
  task automatic applyStimulus(input logic [15:0] pat, input int len, input int respDelay,
                               input bit holdNext, input logic [15:0] nextPat, input int nextLen);
    int eff, hits, expSat;
    logic [2:0] last;
    refModel(pat, len, eff, hits, last);
    expSat = (hits > 3) ? 3 : hits;
    cmd_valid_i   = 1'b1;
    cmd_pattern_i = pat;
    cmd_len_i     = 5'(len);
    checkOutput("idleReady", 32'(cmd_ready_o), 32'd1);
    @(negedge clk);
    cmd_valid_i   = 1'b0;
    cmd_pattern_i = 16'($urandom);
    checkOutput("clearRst", 32'(fsm_rst_o), 32'd1);
    checkOutput("clearBusy", 32'(busy_o), 32'd1);
    checkOutput("clearReady", 32'(cmd_ready_o), 32'd0);
    checkOutput("clearIn", 32'(fsm_in_o), 32'd0);
    for (int k = 0; k < eff; k++) begin
      @(negedge clk);
      checkOutput("runRst", 32'(fsm_rst_o), 32'd0);
      checkOutput("runIn", 32'(fsm_in_o), 32'(pat[k]));
      checkOutput("runNoValid", 32'(res_valid_o), 32'd0);
    end
    @(negedge clk);
    if (holdNext) begin
      cmd_valid_i   = 1'b1;
      cmd_pattern_i = nextPat;
      cmd_len_i     = 5'(nextLen);
    end
    for (int d = 0; d <= respDelay; d++) begin
      checkOutput("respValid", 32'(res_valid_o), 32'd1);
      checkOutput("respHits", 32'(res_hits_o), 32'(hits));
      checkOutput("respLast", 32'(res_last_o), 32'(last));
      checkOutput("respSatHits", 32'(satHits), 32'(expSat));
      checkOutput("respReady", 32'(cmd_ready_o), 32'd0);
      checkOutput("respIn", 32'(fsm_in_o), 32'd0);
      if (d < respDelay) @(negedge clk);
    end
    res_ready_i = 1'b1;
    @(negedge clk);
    res_ready_i = 1'b0;
    if (!holdNext) cmd_valid_i = 1'b0;
    checkOutput("postValid", 32'(res_valid_o), 32'd0);
    checkOutput("postReady", 32'(cmd_ready_o), 32'd1);
    checkOutput("postBusy", 32'(busy_o), 32'd0);
    checkOutput("postRst", 32'(fsm_rst_o), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset_ni      = 1'b0;
    cmd_valid_i   = 1'b0;
    cmd_pattern_i = '0;
    cmd_len_i     = '0;
    res_ready_i   = 1'b0;
    #12;
    checkOutput("rstReady", 32'(cmd_ready_o), 32'd1);
    checkOutput("rstFsmRst", 32'(fsm_rst_o), 32'd1);
    checkOutput("rstIn", 32'(fsm_in_o), 32'd0);
    checkOutput("rstValid", 32'(res_valid_o), 32'd0);
    checkOutput("rstHits", 32'(res_hits_o), 32'd0);
    checkOutput("rstLast", 32'(res_last_o), 32'd0);
    checkOutput("rstBusy", 32'(busy_o), 32'd0);
    @(negedge clk);
    reset_ni = 1'b1;
    checkOutput("relFsmRstHeld", 32'(fsm_rst_o), 32'd1);
    @(negedge clk);
    checkOutput("relFsmRstDrop", 32'(fsm_rst_o), 32'd0);

    applyStimulus(16'h0006, 4, 0, 1'b0, 16'h0, 0);
    applyStimulus(16'hABCD, 0, 1, 1'b0, 16'h0, 0);
    applyStimulus(16'h0492, 12, 0, 1'b0, 16'h0, 0);
    applyStimulus(16'hFFFF, 31, 2, 1'b0, 16'h0, 0);
    applyStimulus(16'h5555, 8, 5, 1'b1, 16'h00F0, 16);
    applyStimulus(16'h00F0, 16, 0, 1'b0, 16'h0, 0);

    // Reset during RUN cycle 2 must discard the command entirely.
    cmd_valid_i   = 1'b1;
    cmd_pattern_i = 16'hFFFF;
    cmd_len_i     = 5'd10;
    @(negedge clk);
    cmd_valid_i = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("run2Busy", 32'(busy_o), 32'd1);
    #2 reset_ni = 1'b0;
    #1;
    checkOutput("midRstReady", 32'(cmd_ready_o), 32'd1);
    checkOutput("midRstFsmRst", 32'(fsm_rst_o), 32'd1);
    checkOutput("midRstIn", 32'(fsm_in_o), 32'd0);
    checkOutput("midRstHits", 32'(res_hits_o), 32'd0);
    checkOutput("midRstBusy", 32'(busy_o), 32'd0);
    @(negedge clk);
    reset_ni = 1'b1;
    repeat (15) begin
      @(negedge clk);
      checkOutput("noResultAfterRst", 32'(res_valid_o), 32'd0);
      checkOutput("idleAfterRst", 32'(busy_o), 32'd0);
    end

    for (int i = 0; i < 40; i++) begin
      applyStimulus(16'($urandom), int'($urandom_range(0, 31)), int'($urandom_range(0, 3)),
                    1'b0, 16'h0, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/mealy_seq_ctrl.md
MEALY_SEQ_CTRL -- requirements
Module: mealy_seq_ctrl

Interface
REQ-001 SHALL have parameter PAT_W, default 16, max pattern length in bits (>=2).
REQ-002 SHALL have parameter CNT_W, default 8, width of the hit counter.
REQ-003 SHALL have parameter HIT_CODE, default 3'b011, the 3-bit FSM output value that is counted.
REQ-004 SHALL have port clk_i, input, 1, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset_ni, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port cmd_valid_i, input, 1, command offered.
REQ-007 SHALL have port cmd_ready_o, output, 1, command accepted when high together with cmd_valid_i.
REQ-008 SHALL have port cmd_pattern_i, input, PAT_W, input bit sequence, LSB first.
REQ-009 SHALL have port cmd_len_i, input, $clog2(PAT_W)+1, number of bits to drive.
REQ-010 SHALL have port fsm_rst_o, output, 1, registered active-high clear pulse to the driven 1-in/3-out Mealy FSM.
REQ-011 SHALL have port fsm_in_o, output, 1, registered bit driven to the FSM input.
REQ-012 SHALL have port fsm_out_i, input, 3, combinational Mealy output of the driven FSM.
REQ-013 SHALL have port res_valid_o, output, 1, result available.
REQ-014 SHALL have port res_ready_i, input, 1, result consumed when high together with res_valid_o.
REQ-015 SHALL have port res_hits_o, output, CNT_W, number of RUN cycles with fsm_out_i==HIT_CODE.
REQ-016 SHALL have port res_last_o, output, 3, fsm_out_i sampled in the final RUN cycle.
REQ-017 SHALL have port busy_o, output, 1, high whenever state is not IDLE.

Function
REQ-018 SHALL implement states IDLE, CLEAR, RUN and RESP.
REQ-019 SHALL drive cmd_ready_o high only in IDLE; accepting a command moves to CLEAR and latches the pattern and the effective length.
REQ-020 SHALL use effective length min(cmd_len_i, PAT_W); larger values are clamped.
REQ-021 SHALL hold fsm_rst_o high for exactly the one CLEAR cycle, and low otherwise.
REQ-022 SHALL leave CLEAR for RUN when the effective length is >0, and for RESP with hits=0 and last=3'b000 when it is 0.
REQ-023 SHALL, in RUN cycle k (k=0..len-1), drive fsm_in_o=pattern[k], and drive fsm_in_o=0 in every other state.
REQ-024 SHALL, in each RUN cycle, sample fsm_out_i in the same cycle and increment the hit counter on a match with HIT_CODE.
REQ-025 SHALL saturate the hit counter at 2^CNT_W-1 with no wrap-around.
REQ-026 SHALL capture res_last_o from the final RUN cycle, then enter RESP on the following edge.
REQ-027 SHALL, in RESP, hold res_valid_o high with res_hits_o and res_last_o stable until res_ready_i is high, then return to IDLE.
REQ-028 SHALL ignore cmd_valid_i outside IDLE, so no command is queued or lost-accepted; a command presented in the same cycle as the RESP handshake is accepted only in the next (IDLE) cycle.
REQ-029 SHALL clear the hit counter and the captured last value on entry to CLEAR.

Reset
REQ-030 SHALL, while reset_ni is low, immediately force state IDLE and set cmd_ready_o=1, fsm_rst_o=1, fsm_in_o=0, res_valid_o=0, res_hits_o=0, res_last_o=0 and busy_o=0.
REQ-031 SHALL drop fsm_rst_o on the first clock edge after reset_ni deasserts.
REQ-032 SHALL, when reset asserts mid-RUN or mid-RESP, discard the result with no res_valid_o pulse.

Configuration
REQ-033 SHALL, with MEALY_SEQ_ABORT_EN defined, add input abort_i, 1 bit; abort_i high in CLEAR or RUN forces IDLE on the next edge and asserts fsm_rst_o for that one IDLE cycle, with no result issued; abort_i is ignored in IDLE and RESP.
REQ-034 SHALL, without MEALY_SEQ_ABORT_EN, have no abort_i port, and every accepted command SHALL reach RESP.

Verification
REQ-035 SHALL cover: pattern 16'h0006, len 4, FSM cleared by fsm_rst_o -> fsm_in_o 0,1,1,0 over 4 RUN cycles, res_hits_o=1, res_last_o=3'b010.
REQ-036 SHALL cover: len 0 -> one fsm_rst_o pulse, then res_valid_o with hits=0 and last=0, and no RUN cycle.
REQ-037 SHALL cover: CNT_W=2, pattern 16'h0492, len 12 -> 4 matches, res_hits_o saturated at 3.
REQ-038 SHALL cover: cmd_len_i=31 with PAT_W=16 -> exactly 16 RUN cycles.
REQ-039 SHALL cover: res_ready_i held low 5 cycles -> res_valid_o and the result stable, cmd_ready_o low, and a second command accepted only after the handshake.
REQ-040 SHALL cover: reset_ni low during RUN cycle 2 -> outputs at reset values immediately, and no res_valid_o afterwards; with MEALY_SEQ_ABORT_EN, abort_i in RUN -> IDLE plus a one-cycle fsm_rst_o, and no result.
